// File: rtl/roce_tx_transfer_scheduler_if.sv
// Requester-side bus of the RoCE TX transfer scheduler: per-requester
// request handshake plus the completion report.
interface roce_tx_transfer_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    s_req_valid;
  logic [NUM_REQ-1:0]    s_req_ready;
  logic [NUM_REQ*32-1:0] s_req_length;
  logic [NUM_REQ*64-1:0] s_req_addr;
  logic                  m_done_valid;
  logic [ID_W-1:0]       m_done_id;
  logic                  m_done_error;

  modport master (
    output s_req_valid, s_req_length, s_req_addr,
    input  s_req_ready, m_done_valid, m_done_id, m_done_error
  );

  modport slave (
    input  s_req_valid, s_req_length, s_req_addr,
    output s_req_ready, m_done_valid, m_done_id, m_done_error
  );
endinterface

// File: rtl/roce_tx_transfer_scheduler.sv
// Round-robin RDMA WRITE scheduler for the RoCE minimal TX stack: one transfer
// at a time, packet counting on the payload tap, PSN tracking.
// Optional idle watchdog: define ROCE_SCHED_WATCHDOG_EN.
module roce_tx_transfer_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int PMTU            = 2048,
  parameter int WATCHDOG_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  roce_tx_transfer_scheduler_if.slave req,
  input  logic [23:0] cfg_rem_qpn,
  input  logic [31:0] cfg_r_key,
  input  logic [31:0] cfg_rem_ip_addr,
  input  logic [23:0] cfg_init_psn,
  input  logic        cfg_psn_load,
  output logic [31:0] m_dma_transfer_length,
  output logic [63:0] m_rem_addr,
  output logic [23:0] m_rem_qpn,
  output logic [23:0] m_rem_psn,
  output logic [31:0] m_r_key,
  output logic [31:0] m_rem_ip_addr,
  output logic        m_start_transfer,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tlast,
  input  logic        mon_early_term,
  output logic        sched_busy
);
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LOG2_PMTU = $clog2(PMTU);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state, state_d;

  logic [ID_W-1:0]              rr_ptr, gnt, done_id;
  logic                         any, hs, err, last_beat, wd_expired;
  logic [23:0]                  psn_reg;
  logic [32:0]                  npkt, pkt_cnt, npkt_next;
  logic [NUM_REQ-1:0][31:0]     len_a;
  logic [NUM_REQ-1:0][63:0]     addr_a;
  logic [31:0]                  sel_len;

  assign len_a     = req.s_req_length;
  assign addr_a    = req.s_req_addr;
  assign sel_len   = len_a[gnt];
  assign npkt_next = ({1'b0, sel_len} + 33'(PMTU - 1)) >> LOG2_PMTU;
  assign last_beat = mon_tvalid && mon_tready && mon_tlast;

  // First valid requester at or after rr_ptr; descending scan so the
  // nearest candidate is written last.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req.s_req_valid[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

  // A PSN preload owns the IDLE cycle, so no grant is offered alongside it.
  assign hs              = (state == IDLE) && !cfg_psn_load && any;
  assign req.s_req_ready = hs ? (NUM_REQ'(1) << gnt) : '0;

`ifdef ROCE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != RUN || (mon_tvalid && mon_tready)) wd_cnt <= '0;
    else                                                   wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expired = (state == RUN) && !(mon_tvalid && mon_tready) &&
                      (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));
`else
  // Watchdog compiled out; never true for a legal (positive) limit.
  assign wd_expired = (WATCHDOG_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (hs) state_d = (sel_len == '0) ? DONE : START;
      START: state_d = RUN;
      RUN:   if ((last_beat && (pkt_cnt + 33'd1 == npkt)) || wd_expired) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psn_reg               <= '0;
      rr_ptr                <= '0;
      done_id               <= '0;
      npkt                  <= '0;
      pkt_cnt               <= '0;
      err                   <= 1'b0;
      m_dma_transfer_length <= '0;
      m_rem_addr            <= '0;
      m_rem_qpn             <= '0;
      m_rem_psn             <= '0;
      m_r_key               <= '0;
      m_rem_ip_addr         <= '0;
    end else begin
      if (state == IDLE) begin
        if (cfg_psn_load) begin
          psn_reg <= cfg_init_psn;
        end else if (hs) begin
          m_dma_transfer_length <= sel_len;
          m_rem_addr            <= addr_a[gnt];
          m_rem_qpn             <= cfg_rem_qpn;
          m_rem_psn             <= psn_reg;
          m_r_key               <= cfg_r_key;
          m_rem_ip_addr         <= cfg_rem_ip_addr;
          npkt                  <= npkt_next;
          done_id               <= gnt;
          err                   <= (sel_len == '0);
          rr_ptr                <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
      end
      if ((state == START || state == RUN) && mon_early_term) err <= 1'b1;
      if (state == RUN) begin
        if (last_beat)  pkt_cnt <= pkt_cnt + 33'd1;
        if (wd_expired) err     <= 1'b1;
      end
      // Completion: PSN advances by the packets the transfer was sized for,
      // whether or not it ended in error.
      if (state == DONE) begin
        psn_reg <= psn_reg + npkt[23:0];
        pkt_cnt <= '0;
        err     <= 1'b0;
      end
    end
  end

  assign m_start_transfer = (state == START);
  assign req.m_done_valid = (state == DONE);
  assign req.m_done_id    = done_id;
  assign req.m_done_error = (state == DONE) && err;
  assign sched_busy       = (state != IDLE);
endmodule

// File: tb/tb_roce_tx_transfer_scheduler.sv
// Directed bench for roce_tx_transfer_scheduler: vector table of single
// transfers plus round-robin, reset-abort and (optional) watchdog sequences.
module tb_roce_tx_transfer_scheduler;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cfg_rem_qpn     = 24'hABCDEF;
  logic [31:0] cfg_r_key       = 32'h1234_5678;
  logic [31:0] cfg_rem_ip_addr = 32'hC0A8_0001;
  logic [23:0] cfg_init_psn    = '0;
  logic        cfg_psn_load    = 1'b0;
  logic [31:0] m_dma_transfer_length;
  logic [63:0] m_rem_addr;
  logic [23:0] m_rem_qpn, m_rem_psn;
  logic [31:0] m_r_key, m_rem_ip_addr;
  logic        m_start_transfer, sched_busy;
  logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0, mon_early_term = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  roce_tx_transfer_scheduler_if #(.NUM_REQ(NR)) rif ();

  roce_tx_transfer_scheduler #(.NUM_REQ(NR), .PMTU(2048), .WATCHDOG_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .req(rif),
    .cfg_rem_qpn(cfg_rem_qpn), .cfg_r_key(cfg_r_key), .cfg_rem_ip_addr(cfg_rem_ip_addr),
    .cfg_init_psn(cfg_init_psn), .cfg_psn_load(cfg_psn_load),
    .m_dma_transfer_length(m_dma_transfer_length), .m_rem_addr(m_rem_addr),
    .m_rem_qpn(m_rem_qpn), .m_rem_psn(m_rem_psn), .m_r_key(m_r_key),
    .m_rem_ip_addr(m_rem_ip_addr), .m_start_transfer(m_start_transfer),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .mon_early_term(mon_early_term), .sched_busy(sched_busy)
  );

  typedef struct {
    bit          load;
    logic [23:0] load_psn;
    int          id;
    logic [31:0] len;
    logic [63:0] addr;
    int          npkt;
    logic [23:0] exp_psn;
    int          early;
    bit          exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] len, input logic [63:0] addr);
    rif.s_req_length[id*32 +: 32] = len;
    rif.s_req_addr[id*64 +: 64]   = addr;
    rif.s_req_valid[id]           = 1'b1;
  endtask

  // Wait for the grant, check the captured config, play npkt packets on the
  // monitor tap and check the completion pulse.
  task automatic xfer(input int id, input logic [31:0] len, input logic [63:0] addr,
                      input int npkt, input logic [23:0] psn, input int early,
                      input bit exp_err, input bit hold);
    bit got;
    got = 1'b0;
    #1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (rif.s_req_ready != '0) got = 1'b1;
      else tick();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant expected id %0d", id);
      return;
    end
    chk("ready_onehot", 64'(rif.s_req_ready), 64'(1) << id);
    tick();
    if (!hold) rif.s_req_valid = '0;
    chk("start_pulse", 64'(m_start_transfer), 64'(len != 0));
    chk("cfg_len", 64'(m_dma_transfer_length), 64'(len));
    chk("cfg_addr", m_rem_addr, addr);
    chk("cfg_psn", 64'(m_rem_psn), 64'(psn));
    chk("cfg_qpn", 64'(m_rem_qpn), 64'h00ABCDEF);
    if (len == 0) begin
      chk("zl_done_valid", 64'(rif.m_done_valid), 64'd1);
      chk("zl_done_err", 64'(rif.m_done_error), 64'd1);
      chk("zl_done_id", 64'(rif.m_done_id), 64'(id));
      tick();
      return;
    end
    tick();
    chk("start_single", 64'(m_start_transfer), 64'd0);
    for (int p = 0; p < npkt; p++) begin
      // stalled tlast, mid-packet beat, then the real last beat
      mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b1; tick();
      mon_tready = 1'b1; mon_tlast = 1'b0; tick();
      chk("no_early_done", 64'(rif.m_done_valid), 64'd0);
      mon_tlast = 1'b1; mon_early_term = (p == early); tick();
      mon_tvalid = 1'b0; mon_tlast = 1'b0; mon_early_term = 1'b0;
      if (p < npkt - 1) chk("no_early_done", 64'(rif.m_done_valid), 64'd0);
    end
    chk("done_valid", 64'(rif.m_done_valid), 64'd1);
    chk("done_id", 64'(rif.m_done_id), 64'(id));
    chk("done_err", 64'(rif.m_done_error), 64'(exp_err));
    chk("cfg_held", 64'(m_dma_transfer_length), 64'(len));
    tick();
    chk("idle_after_done", 64'({sched_busy, rif.m_done_valid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 24'h000010, 0, 32'd100,  64'h1000, 1, 24'h000010, -1, 1'b0};
    vt[1] = '{1'b0, 24'h0,      1, 32'd5000, 64'h2000, 3, 24'h000011, -1, 1'b0};
    vt[2] = '{1'b1, 24'hFFFFFE, 2, 32'd4096, 64'h3000, 2, 24'hFFFFFE, -1, 1'b0};
    vt[3] = '{1'b0, 24'h0,      3, 32'd2048, 64'h4000, 1, 24'h000000, -1, 1'b0};
    vt[4] = '{1'b0, 24'h0,      0, 32'd0,    64'h5000, 0, 24'h000001, -1, 1'b1};
    vt[5] = '{1'b0, 24'h0,      1, 32'd2049, 64'h6000, 2, 24'h000001,  0, 1'b1};
    vt[6] = '{1'b0, 24'h0,      2, 32'd1,    64'h7000, 1, 24'h000003, -1, 1'b0};
    vt[7] = '{1'b0, 24'h0,      3, 32'd2047, 64'h8000, 1, 24'h000004, -1, 1'b0};

    rif.s_req_valid  = '0;
    rif.s_req_length = '0;
    rif.s_req_addr   = '0;
    tick(); tick();
    chk("rst_start", 64'(m_start_transfer), 64'd0);
    chk("rst_busy", 64'(sched_busy), 64'd0);
    chk("rst_done", 64'({rif.m_done_valid, rif.m_done_error, rif.m_done_id}), 64'd0);
    chk("rst_cfg", 64'({m_rem_psn, m_dma_transfer_length}), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].id, vt[i].len, vt[i].addr);
      if (vt[i].load) begin
        cfg_psn_load = 1'b1;
        cfg_init_psn = vt[i].load_psn;
        #1;
        chk("load_blocks_grant", 64'(rif.s_req_ready), 64'd0);
        tick();
        cfg_psn_load = 1'b0;
      end
      xfer(vt[i].id, vt[i].len, vt[i].addr, vt[i].npkt, vt[i].exp_psn,
           vt[i].early, vt[i].exp_err, 1'b0);
    end

    // round robin with 0, 2, 3 held from rr_ptr = 0
    set_req(0, 32'd100, 64'hA000);
    set_req(2, 32'd100, 64'hA200);
    set_req(3, 32'd100, 64'hA300);
    xfer(0, 32'd100, 64'hA000, 1, 24'h000005, -1, 1'b0, 1'b1);
    xfer(2, 32'd100, 64'hA200, 1, 24'h000006, -1, 1'b0, 1'b1);
    xfer(3, 32'd100, 64'hA300, 1, 24'h000007, -1, 1'b0, 1'b1);
    xfer(0, 32'd100, 64'hA000, 1, 24'h000008, -1, 1'b0, 1'b0);

    // reset in RUN aborts; rr_ptr and PSN return to 0
    set_req(1, 32'd4096, 64'hB000);
    #1;
    chk("rr_next_is_1", 64'(rif.s_req_ready), 64'd2);
    tick(); tick();
    rst = 1'b1;
    tick();
    rif.s_req_valid = '0;
    rst = 1'b0;
    chk("abort_busy", 64'(sched_busy), 64'd0);
    chk("abort_cfg", 64'({m_rem_psn, m_dma_transfer_length}), 64'd0);
    set_req(0, 32'd300, 64'hC000);
    set_req(1, 32'd300, 64'hC100);
    xfer(0, 32'd300, 64'hC000, 1, 24'h000000, -1, 1'b0, 1'b0);

`ifdef ROCE_SCHED_WATCHDOG_EN
    begin
      int c;
      c = 0;
      set_req(2, 32'd100, 64'hD000);
      #1;
      tick();
      rif.s_req_valid = '0;
      tick();
      while (!rif.m_done_valid && c < 300) begin
        tick();
        c++;
      end
      chk("wd_cycles", 64'(c), 64'd100);
      chk("wd_err", 64'(rif.m_done_error), 64'd1);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
